lcd_status_reader: RTL and testbench

//  HD44780-compatible LCD read-cycle engine: the reader side of the LCD bus that the output

---
 rtl/lcd_bus_pkg.sv | 34 +++
 rtl/lcd_status_reader.sv | 169 ++++++++++++++++
 tb/tb_lcd_status_reader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_pkg.sv
// rtl/lcd_bus_pkg.sv - shared LCD bus state encoding, timing defaults and RS codes
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_E_HI  = 3'd2,
        ST_E_LO  = 3'd3,
        ST_DONE  = 3'd4
    } lcd_state_e;

    // Defaults for a 50 MHz clock
    localparam int DEF_SETUP_CYC  = 3;
    localparam int DEF_E_HIGH_CYC = 13;
    localparam int DEF_E_LOW_CYC  = 13;
    localparam int DEF_POLL_MAX   = 4096;

    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Counter width that can hold n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_status_reader.sv
// rtl/lcd_status_reader.sv - HD44780 read-cycle engine (busy flag/address or RAM byte)
//
// Ports:
//   clock_i      system clock (50 MHz)
//   reset_i      synchronous active-low reset
//   start_i      read request, accepted only in IDLE
//   rs_sel_i     0 = busy-flag/address read, 1 = data RAM read (latched)
//   poll_i       repeat status reads until BF=0 (latched, ignored for data reads)
//   db_in_i      LCD data bus input
//   lcd_rs_o     RS during owned cycles
//   lcd_rw_o     RW, 1 throughout owned cycles
//   lcd_e_o      enable strobe
//   bus_grant_o  bus ownership, first SETUP cycle through last E_LO cycle
//   busy_o       any state except IDLE
//   done_o       one-cycle result-valid pulse
//   rd_data_o    last sampled byte
//   bf_o         busy flag of last status read (0 after data reads)
//   addr_o       address counter of last status read
//   timeout_o    poll exhausted POLL_MAX reads with BF=1
module lcd_status_reader
    import lcd_bus_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int E_HIGH_CYC = DEF_E_HIGH_CYC,
    parameter int E_LOW_CYC  = DEF_E_LOW_CYC,
    parameter int POLL_MAX   = DEF_POLL_MAX
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       rs_sel_i,
    input  logic       poll_i,
    input  logic [7:0] db_in_i,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    output logic       bus_grant_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rd_data_o,
    output logic       bf_o,
    output logic [6:0] addr_o,
    output logic       timeout_o
);

    localparam int PH_W = cnt_w(max3(SETUP_CYC, E_HIGH_CYC, E_LOW_CYC));
    localparam int PC_W = cnt_w(POLL_MAX);

    localparam logic [PH_W-1:0] PH_SETUP = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0] PH_E_HI  = PH_W'(E_HIGH_CYC - 1);
    localparam logic [PH_W-1:0] PH_E_LO  = PH_W'(E_LOW_CYC - 1);
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(POLL_MAX - 1);

    lcd_state_e      state_q;
    logic [PH_W-1:0] ph_q;
    logic [PC_W-1:0] pc_q;
    logic            rs_l_q;
    logic            poll_l_q;
    logic [7:0]      sample_q;
    logic            lcd_rs_q, lcd_rw_q, lcd_e_q, grant_q, busy_q, done_q;
    logic [7:0]      rd_data_q;
    logic            bf_q;
    logic [6:0]      addr_q;
    logic            timeout_q;

    // Polling continues only for status reads that still report BF=1
    logic poll_more;
    assign poll_more = poll_l_q && (rs_l_q == RS_INSTR) && sample_q[7];

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            pc_q      <= '0;
            rs_l_q    <= 1'b0;
            poll_l_q  <= 1'b0;
            sample_q  <= '0;
            lcd_rs_q  <= 1'b0;
            lcd_rw_q  <= 1'b0;
            lcd_e_q   <= 1'b0;
            grant_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            bf_q      <= 1'b0;
            addr_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        rs_l_q   <= rs_sel_i;
                        poll_l_q <= poll_i;
                        pc_q     <= '0;
                        ph_q     <= PH_SETUP;
                        lcd_rs_q <= rs_sel_i;
                        lcd_rw_q <= 1'b1;
                        grant_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (ph_q == '0) begin
                        ph_q    <= PH_E_HI;
                        lcd_e_q <= 1'b1;
                        state_q <= ST_E_HI;
                    end else begin
                        ph_q <= ph_q - 1'b1;
                    end
                end
                ST_E_HI: begin
                    if (ph_q == '0) begin
                        // DB is valid late in the E pulse; capture on the falling edge
                        sample_q <= db_in_i;
                        ph_q     <= PH_E_LO;
                        lcd_e_q  <= 1'b0;
                        state_q  <= ST_E_LO;
                    end else begin
                        ph_q <= ph_q - 1'b1;
                    end
                end
                ST_E_LO: begin
                    if (ph_q != '0) begin
                        ph_q <= ph_q - 1'b1;
                    end else if (poll_more && (pc_q != PC_LAST)) begin
                        pc_q    <= pc_q + 1'b1;
                        ph_q    <= PH_SETUP;
                        state_q <= ST_SETUP;
                    end else begin
                        lcd_rs_q  <= 1'b0;
                        lcd_rw_q  <= 1'b0;
                        grant_q   <= 1'b0;
                        done_q    <= 1'b1;
                        rd_data_q <= sample_q;
                        timeout_q <= poll_more;
                        if (rs_l_q == RS_INSTR) begin
                            bf_q   <= sample_q[7];
                            addr_q <= sample_q[6:0];
                        end else begin
                            bf_q <= 1'b0;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lcd_rs_o    = lcd_rs_q;
    assign lcd_rw_o    = lcd_rw_q;
    assign lcd_e_o     = lcd_e_q;
    assign bus_grant_o = grant_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_data_o   = rd_data_q;
    assign bf_o        = bf_q;
    assign addr_o      = addr_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_lcd_status_reader.sv
// tb/tb_lcd_status_reader.sv - directed self-checking bench for lcd_status_reader
module tb_lcd_status_reader;

    logic       clk;
    logic       rst_n;
    logic       start, start2;
    logic       rs_sel, poll;
    logic [7:0] db_in, db_fixed;
    logic       use_model;

    logic       lcd_rs, lcd_rw, lcd_e, grant, busy, done, bf, tmo;
    logic [7:0] rd_data;
    logic [6:0] addr;

    logic       lcd_rs2, lcd_rw2, lcd_e2, grant2, busy2, done2, bf2, tmo2;
    logic [7:0] rd_data2;
    logic [6:0] addr2;

    int total = 0;
    int bad   = 0;

    int e_hi_cnt, e_pulses, e_falls, done_cnt, rs_drop, rw_drop, e_pulses2;

    lcd_status_reader dut (
        .clock_i(clk), .reset_i(rst_n), .start_i(start), .rs_sel_i(rs_sel),
        .poll_i(poll), .db_in_i(db_in), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw),
        .lcd_e_o(lcd_e), .bus_grant_o(grant), .busy_o(busy), .done_o(done),
        .rd_data_o(rd_data), .bf_o(bf), .addr_o(addr), .timeout_o(tmo)
    );

    lcd_status_reader #(.POLL_MAX(4)) dut4 (
        .clock_i(clk), .reset_i(rst_n), .start_i(start2), .rs_sel_i(rs_sel),
        .poll_i(poll), .db_in_i(db_in), .lcd_rs_o(lcd_rs2), .lcd_rw_o(lcd_rw2),
        .lcd_e_o(lcd_e2), .bus_grant_o(grant2), .busy_o(busy2), .done_o(done2),
        .rd_data_o(rd_data2), .bf_o(bf2), .addr_o(addr2), .timeout_o(tmo2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // LCD model: BF=1 for the first three reads, then idle with address 0x12
    always_comb begin
        db_in = db_fixed;
        if (use_model) db_in = (e_falls < 3) ? 8'h80 : 8'h12;
    end

    always @(negedge clk) begin
        if (lcd_e) e_hi_cnt++;
        if (grant && !lcd_rs) rs_drop++;
        if (grant && !lcd_rw) rw_drop++;
        if (done) done_cnt++;
    end
    always @(posedge lcd_e)  e_pulses++;
    always @(negedge lcd_e)  e_falls++;
    always @(posedge lcd_e2) e_pulses2++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counters();
        e_hi_cnt = 0; e_pulses = 0; e_falls = 0; rs_drop = 0; rw_drop = 0; e_pulses2 = 0;
    endtask

    // Drive start for one edge (edge T); returns #1 after edge T
    task automatic pulse_start(input logic which, input logic rs, input logic pl);
        @(negedge clk);
        rs_sel = rs;
        poll   = pl;
        if (which) start2 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Edges after the acceptance edge until done is seen (bounded)
    task automatic wait_done(input logic which, output int n);
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if ((which ? done2 : done) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int dc;

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; rs_sel = 1'b0; poll = 1'b0;
        db_fixed = 8'h00; use_model = 1'b0;
        clr_counters();
        done_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lcd_rs_rw_e", 32'({lcd_rs, lcd_rw, lcd_e}), 32'h0);
        chk("rst_grant_busy_done", 32'({grant, busy, done}), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_bf_addr_tmo", 32'({bf, addr, tmo}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: reset asserted mid E_HI
        db_fixed = 8'h45;
        pulse_start(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !lcd_e; i++) begin
            @(posedge clk);
            #1;
        end
        chk("t1_e_reached", 32'(lcd_e), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        dc = done_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t1_e_drop", 32'(lcd_e), 32'h0);
        chk("t1_grant_drop", 32'(grant), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("t1_outs", 32'({lcd_rs, lcd_rw, lcd_e, grant, busy, done, bf, tmo}), 32'h0);
        chk("t1_data", 32'({rd_data, addr}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t1_no_done", 32'(done_cnt), 32'(dc));

        // 2: single status read; done in cycle T+30 = 29 edges after acceptance
        clr_counters();
        db_fixed = 8'h45;
        pulse_start(1'b0, 1'b0, 1'b0);
        wait_done(1'b0, n);
        chk("t2_latency", 32'(n), 32'd29);
        chk("t2_e_high_cycles", 32'(e_hi_cnt), 32'd13);
        chk("t2_e_pulses", 32'(e_pulses), 32'd1);
        chk("t2_rd_data", 32'(rd_data), 32'h45);
        chk("t2_bf", 32'(bf), 32'h0);
        chk("t2_addr", 32'(addr), 32'h45);
        chk("t2_tmo", 32'(tmo), 32'h0);
        chk("t2_rw_held", 32'(rw_drop), 32'd0);
        chk("t2_done_rw_grant", 32'({lcd_rw, grant, busy}), 32'b001);
        @(posedge clk);
        #1;
        chk("t2_done_pulse", 32'({done, busy}), 32'h0);

        // 3: poll, BF=1 three times then 0x12 -> 4 reads, 1+4*29 cycles
        clr_counters();
        use_model = 1'b1;
        pulse_start(1'b0, 1'b0, 1'b1);
        wait_done(1'b0, n);
        chk("t3_latency", 32'(n), 32'd116);
        chk("t3_e_pulses", 32'(e_pulses), 32'd4);
        chk("t3_bf", 32'(bf), 32'h0);
        chk("t3_addr", 32'(addr), 32'h12);
        chk("t3_rd_data", 32'(rd_data), 32'h12);
        chk("t3_tmo", 32'(tmo), 32'h0);
        use_model = 1'b0;
        repeat (2) @(posedge clk);

        // 4: POLL_MAX=4 instance, BF stuck at 1 -> 4 reads then timeout
        clr_counters();
        db_fixed = 8'h80;
        pulse_start(1'b1, 1'b0, 1'b1);
        wait_done(1'b1, n);
        chk("t4_latency", 32'(n), 32'd116);
        chk("t4_e_pulses", 32'(e_pulses2), 32'd4);
        chk("t4_tmo", 32'(tmo2), 32'h1);
        chk("t4_bf", 32'(bf2), 32'h1);
        chk("t4_rd_data", 32'(rd_data2), 32'h80);
        chk("t4_main_idle", 32'(e_pulses), 32'd0);
        repeat (2) @(posedge clk);

        // 5: data read with poll=1 -> one cycle, RS=1 throughout
        clr_counters();
        db_fixed = 8'hA5;
        pulse_start(1'b0, 1'b1, 1'b1);
        #1;
        chk("t5_rs_high", 32'(lcd_rs), 32'h1);
        wait_done(1'b0, n);
        chk("t5_latency", 32'(n), 32'd29);
        chk("t5_e_pulses", 32'(e_pulses), 32'd1);
        chk("t5_rs_held", 32'(rs_drop), 32'd0);
        chk("t5_rd_data", 32'(rd_data), 32'hA5);
        chk("t5_bf", 32'(bf), 32'h0);
        chk("t5_tmo", 32'(tmo), 32'h0);
        chk("t5_addr_held", 32'(addr), 32'h12);
        repeat (2) @(posedge clk);

        // 6: start at T+5 and in the DONE cycle are both ignored
        clr_counters();
        db_fixed = 8'h07;
        dc = done_cnt;
        pulse_start(1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 5;
        for (int i = 6; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("t6_latency", 32'(n), 32'd29);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t6_done_start_busy", 32'(busy), 32'h0);
        repeat (40) @(posedge clk);
        #1;
        chk("t6_one_done", 32'(done_cnt - dc), 32'd1);
        chk("t6_e_pulses", 32'(e_pulses), 32'd1);
        chk("t6_idle", 32'({busy, grant}), 32'h0);
        chk("t6_addr", 32'(addr), 32'h07);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
